bcd_count_src: RTL

- Upstream value source for the 4-digit seven-segment display path.
- Produces a 16-bit packed-BCD count, 4 digits, digit 3 in [15:12]. It replaces the raw switch bus as the 16-bit input to the digit multiplexer.
- Internal prescaler turns the system clock into a count tick.
- Counts up or down with decimal carry/borrow across digits; supports synchronous load of a preset value.

---
 rtl/bcd_count_src_if.sv | 14 +
 rtl/bcd_count_src.sv | 112 +++++++++++
 2 files changed

// File: rtl/bcd_count_src_if.sv
// Control and value bus between the BCD count source and its consumer.
// master drives enable/direction/load; slave (the counter) returns count and pulses.
interface bcd_count_src_if;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        tick;
    logic        wrap;

    modport master (output en, up, load, load_val, input count, tick, wrap);
    modport slave  (input en, up, load, load_val, output count, tick, wrap);
endinterface

// File: rtl/bcd_count_src.sv
// 4-digit packed-BCD up/down counter with prescaler, feeding the 7-segment display mux.
// Optional macro BCD_COUNT_SAT_EN: saturate at 9999/0000 instead of wrapping (wrap tied low).

// One decimal digit: applies the incoming carry/borrow and reports carry/borrow out.
module bcd_count_digit (
    input  logic [3:0] i_d,
    input  logic       i_up,
    input  logic       i_cin,
    output logic [3:0] o_d,
    output logic       o_cout
);
    always_comb begin
        o_d    = i_d;
        o_cout = 1'b0;
        if (i_cin) begin
            if (i_up) begin
                if (i_d == 4'd9) begin
                    o_d    = 4'd0;
                    o_cout = 1'b1;
                end else begin
                    o_d = i_d + 4'd1;
                end
            end else begin
                if (i_d == 4'd0) begin
                    o_d    = 4'd9;
                    o_cout = 1'b1;
                end else begin
                    o_d = i_d - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_count_src #(
    parameter int DIV   = 100_000_000,
    parameter int DIV_W = 27
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_count_src_if.slave bus
);
    localparam int NUM_DIGITS = 4;

    logic [DIV_W-1:0]                r_presc;
    logic [NUM_DIGITS-1:0][3:0]      r_count;
    logic [NUM_DIGITS-1:0][3:0]      w_next;
    logic [NUM_DIGITS-1:0][3:0]      w_clamp;
    logic [NUM_DIGITS:0]             w_carry;
    logic                            r_tick;
    logic                            w_term;

    assign w_term     = bus.en && (r_presc == DIV_W'(DIV - 1));
    assign w_carry[0] = 1'b1;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
            bcd_count_digit u_dig (
                .i_d    (r_count[g]),
                .i_up   (bus.up),
                .i_cin  (w_carry[g]),
                .o_d    (w_next[g]),
                .o_cout (w_carry[g+1])
            );
            assign w_clamp[g] = (bus.load_val[4*g +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*g +: 4];
        end
    endgenerate

    // Carry out of the top digit marks a rollover (or, saturating, a blocked step).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (bus.load) begin
            r_presc <= '0;
            r_count <= w_clamp;
            r_tick  <= 1'b0;
        end else if (w_term) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
`ifdef BCD_COUNT_SAT_EN
            if (!w_carry[NUM_DIGITS])
                r_count <= w_next;
`else
            r_count <= w_next;
`endif
        end else begin
            if (bus.en)
                r_presc <= r_presc + DIV_W'(1);
            r_tick <= 1'b0;
        end
    end

`ifdef BCD_COUNT_SAT_EN
    assign bus.wrap = 1'b0;
`else
    logic r_wrap;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.load)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_term && w_carry[NUM_DIGITS];
    end

    assign bus.wrap = r_wrap;
`endif

    assign bus.count = r_count;
    assign bus.tick  = r_tick;
endmodule
